// File: rtl/spi_bram_rd_framer.sv
// spi_bram_rd_framer: polls the SPI receive buffer, fetches bytes by address and
// turns length-prefixed frames into a valid/ready payload stream with end-of-frame.
module spi_bram_rd_framer #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 11,
    parameter int RD_LAT    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 not_empty,
    output logic                 rd_en,
    output logic [ADDRWIDTH-1:0] rd_addr,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic                 m_valid,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic [15:0]          frame_cnt
);
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, HOLD} state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        lat_cnt;
    logic [DATAWIDTH-1:0] byte_q;
    logic [DATAWIDTH-1:0] rem;
    logic                 lat_done;
    logic                 accept;

    assign lat_done = lat_cnt == LW'(RD_LAT - 1);
    assign accept   = state == HOLD && m_ready;
    assign rd_en    = state == FETCH;
    assign m_valid  = state == HOLD;
    assign m_data   = byte_q;
    assign m_last   = m_valid && rem == DATAWIDTH'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = enable && not_empty ? FETCH : IDLE;
            FETCH:   state_nxt = lat_done ? DECODE : FETCH;
            // rem==0 means the byte just fetched is a header
            DECODE:  state_nxt = rem == '0 ? IDLE : HOLD;
            HOLD:    state_nxt = m_ready ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            byte_q    <= '0;
            rem       <= '0;
            rd_addr   <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= state == FETCH && !lat_done ? lat_cnt + 1'b1 : '0;
            if (state == FETCH && lat_done) begin
                byte_q  <= rd_data;
                rd_addr <= rd_addr + 1'b1;
            end
            if (state == DECODE && rem == '0)
                rem <= byte_q;
            if (accept) begin
                rem <= rem - 1'b1;
                if (rem == DATAWIDTH'(1))
                    frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_spi_bram_rd_framer.sv
// tb_spi_bram_rd_framer: table-driven frame vectors against a latency-accurate buffer
// model, plus directed sequences for wrap, backpressure, reset and enable/empty handling.
module tb_spi_bram_rd_framer;
    localparam int RD_LAT = 4;

    logic        clk = 0, rst = 1, enable = 0, m_ready = 1, ne_en = 1;
    logic        not_empty, rd_en, m_valid, m_last;
    logic [10:0] rd_addr, wptr = '0;
    logic [7:0]  rd_data, m_data;
    logic [15:0] frame_cnt;
    logic [7:0]  mem [2048];
    int          lat = 0;
    int          checks = 0, fails = 0, exp_frames = 0;
    logic [8:0]  out_q[$];
    logic        pv = 0, pr = 0, pl = 0;
    logic [7:0]  pd = 0;

    typedef struct {
        int          nin;
        logic [63:0] din;
        int          nout;
        logic [63:0] dout;
        logic [7:0]  lastmask;
        int          frames;
    } vec_t;

    vec_t tbl[7];

    spi_bram_rd_framer #(.DATAWIDTH(8), .ADDRWIDTH(11), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .not_empty(not_empty),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Buffer model: data is only correct RD_LAT cycles after rd_en rises
    always @(posedge clk) lat <= rd_en ? lat + 1 : 0;
    assign rd_data   = (rd_en && lat == RD_LAT - 1) ? mem[rd_addr] : 8'hEE;
    assign not_empty = ne_en && (rd_addr != wptr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && rd_en) chk("valid_during_rd_en", 1, 0);
            if (pv && !pr) begin
                chk("hold_valid", {31'd0, m_valid}, 1);
                chk("hold_data", {24'd0, m_data}, {24'd0, pd});
                chk("hold_last", {31'd0, m_last}, {31'd0, pl});
            end
            if (m_valid && m_ready) out_q.push_back({m_last, m_data});
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end else begin
            pv = 0; pr = 0;
        end
    end

    function automatic vec_t mk(int ni, logic [63:0] di, int no, logic [63:0] dx,
                                logic [7:0] lm, int fr);
        vec_t v;
        v.nin = ni; v.din = di << (8 * (8 - ni));
        v.nout = no; v.dout = dx << (8 * (8 - no));
        v.lastmask = lm; v.frames = fr;
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int n = 0;
        out_q.delete();
        for (int i = 0; i < v.nin; i++) begin
            mem[wptr] = v.din[63 - 8 * i -: 8];
            wptr = wptr + 1'b1;
        end
        exp_frames += v.frames;
        while ((rd_addr != wptr || m_valid || rd_en) && n < 400) begin cyc(1); n++; end
        chk({tag, "_timeout"}, n >= 400, 0);
        cyc(3);
        chk({tag, "_count"}, out_q.size(), v.nout);
        for (int i = 0; i < v.nout && i < out_q.size(); i++) begin
            chk({tag, "_data"}, {24'd0, out_q[i][7:0]}, {24'd0, v.dout[63 - 8 * i -: 8]});
            chk({tag, "_last"}, {31'd0, out_q[i][8]}, {31'd0, v.lastmask[i]});
        end
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, exp_frames);
        chk({tag, "_rd_addr"}, {21'd0, rd_addr}, {21'd0, wptr});
    endtask

    task automatic wait_rise(input string tag);
        logic prev = rd_en;
        int n = 0;
        while (n < 100) begin
            cyc(1); n++;
            if (rd_en && !prev) break;
            prev = rd_en;
        end
        chk({tag, "_rise_timeout"}, n >= 100, 0);
    endtask

    task automatic wait_size(input int s, input string tag);
        int n = 0;
        while (out_q.size() < s && n < 100) begin cyc(1); n++; end
        chk({tag, "_size_timeout"}, n >= 100, 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_valid && n < 100) begin cyc(1); n++; end
        chk({tag, "_valid_timeout"}, n >= 100, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        tbl[0] = mk(4, 64'h03AABBCC,   3, 64'hAABBCC, 8'b100, 1);
        tbl[1] = mk(4, 64'h00021122,   2, 64'h1122,   8'b10,  1);
        tbl[2] = mk(2, 64'h015A,       1, 64'h5A,     8'b1,   1);
        tbl[3] = mk(5, 64'h02010201FF, 3, 64'h0102FF, 8'b110, 2);
        tbl[4] = mk(2, 64'h0000,       0, 64'h0,      8'b0,   0);
        tbl[5] = mk(4, 64'h03A1A2A3,   3, 64'hA1A2A3, 8'b100, 1);
        tbl[6] = mk(2, 64'h01E7,       1, 64'hE7,     8'b1,   1);

        cyc(2);
        chk("reset_outputs", {rd_en, m_valid, m_last, rd_addr, m_data, frame_cnt}, 0);
        rst = 0; enable = 1;
        cyc(1);

        for (int i = 0; i < 5; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Advance the read pointer to 2046 with empty frames, then span the wrap
        for (int a = int'(wptr); a < 2046; a++) mem[a] = 8'h00;
        wptr = 11'd2046;
        cnt = 0;
        while (rd_addr != wptr && cnt < 20000) begin cyc(1); cnt++; end
        cyc(3);
        chk("fill_timeout", cnt >= 20000, 0);
        chk("fill_no_output", out_q.size(), 0);
        chk("fill_frame_cnt", {16'd0, frame_cnt}, exp_frames);
        apply_vec(tbl[5], "wrap");

        // Backpressure on the second payload byte
        out_q.delete();
        mem[wptr] = 8'h02; mem[wptr + 11'd1] = 8'hC1; mem[wptr + 11'd2] = 8'hC2;
        wptr = wptr + 11'd3;
        exp_frames++;
        wait_size(1, "bp");
        m_ready = 0;
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("bp_valid", {31'd0, m_valid}, 1);
            chk("bp_data", {24'd0, m_data}, 32'hC2);
            chk("bp_last", {31'd0, m_last}, 1);
            chk("bp_no_rd_en", {31'd0, rd_en}, 0);
        end
        m_ready = 1;
        cyc(1);
        chk("bp_valid_drop", {31'd0, m_valid}, 0);
        chk("bp_frame_cnt", {16'd0, frame_cnt}, exp_frames);
        chk("bp_stream", out_q.size() == 2 ? {out_q[0], out_q[1]} : 18'h0, {9'h0C1, 9'h1C2});

        // Reset in the middle of a payload, rem == 2
        out_q.delete();
        mem[wptr] = 8'h04; mem[wptr + 11'd1] = 8'hD1; mem[wptr + 11'd2] = 8'hD2;
        mem[wptr + 11'd3] = 8'hD3; mem[wptr + 11'd4] = 8'hD4;
        wptr = wptr + 11'd5;
        wait_size(2, "rst");
        m_ready = 0;
        wait_valid("rst");
        chk("rst_pre_data", {24'd0, m_data}, 32'hD3);
        chk("rst_pre_last", {31'd0, m_last}, 0);
        rst = 1;
        #1;
        chk("rst_async_outputs", {rd_en, m_valid, m_last, rd_addr, m_data, frame_cnt}, 0);
        cyc(1);
        chk("rst_edge_outputs", {rd_en, m_valid, m_last, rd_addr, m_data, frame_cnt}, 0);
        wptr = '0;
        exp_frames = 0;
        m_ready = 1;
        rst = 0;
        apply_vec(tbl[6], "post_rst");

        // Empty buffer never fetches; enable dropped during a payload fetch
        out_q.delete();
        ne_en = 0;
        mem[wptr] = 8'h01; mem[wptr + 11'd1] = 8'hF1;
        wptr = wptr + 11'd2;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); cnt += rd_en; end
        chk("empty_no_rd_en", cnt, 0);
        ne_en = 1;
        wait_rise("en1");
        wait_rise("en2");
        enable = 0;
        exp_frames++;
        wait_size(1, "en");
        cyc(3);
        chk("en_data", out_q.size() > 0 ? {23'd0, out_q[0]} : 32'hFFFF, 32'h1F1);
        chk("en_frame_cnt", {16'd0, frame_cnt}, exp_frames);
        mem[wptr] = 8'h01; mem[wptr + 11'd1] = 8'hF2;
        wptr = wptr + 11'd2;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); cnt += rd_en; end
        chk("disabled_no_rd_en", cnt, 0);
        chk("disabled_rd_addr", {21'd0, rd_addr}, {21'd0, wptr - 11'd2});
        enable = 1;
        apply_vec(mk(0, 64'h0, 1, 64'hF2, 8'b1, 1), "reenable");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
